// File: rtl/relu_maxpool2x2_if.sv
// rtl/relu_maxpool2x2_if.sv - pixel-in / pooled-out stream bundle for relu_maxpool2x2
interface relu_maxpool2x2_if #(
    parameter int DW = 9,
    parameter int CW = 5
) ();
    logic          clr;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_col;
    logic [CW-1:0] out_row;
    logic          frame_done;

    // Producer / consumer side: drives pixels, receives pooled results
    modport master (
        output clr, in_valid, in_data,
        input  out_valid, out_data, out_col, out_row, frame_done
    );

    // Pooling stage side
    modport slave (
        input  clr, in_valid, in_data,
        output out_valid, out_data, out_col, out_row, frame_done
    );
endinterface

// File: rtl/relu_maxpool2x2.sv
// rtl/relu_maxpool2x2.sv - streaming ReLU followed by 2x2 stride-2 max pooling
module relu_maxpool2x2 #(
    parameter int DW    = 9,
    parameter int IMG_W = 26,
    parameter int IMG_H = 26,
    parameter int CW    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    relu_maxpool2x2_if.slave bus
);
    localparam int PW = IMG_W / 2;
    localparam int PH = IMG_H / 2;
    localparam int AW = (PW > 1) ? $clog2(PW) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [CW-1:0] ROW_LAST = CW'(IMG_H - 1);
    localparam logic [CW-1:0] PH_C     = CW'(PH);
    localparam logic [CW-1:0] PCOL_END = CW'(PW - 1);
    localparam logic [CW-1:0] PROW_END = CW'(PH - 1);

    logic [CW-1:0] col_q, col_d;
    logic [CW-1:0] row_q, row_d;
    logic [DW-1:0] pair_q, pair_d;
    logic          pair_vld_q, pair_vld_d;
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic [CW-1:0] out_col_q, out_col_d;
    logic [CW-1:0] out_row_q, out_row_d;
    logic          frame_done_q, frame_done_d;

    // Half-width line buffer holding the horizontal maxima of the even row
    logic [DW-1:0] line_mem [0:PW-1];
    logic [AW-1:0] lb_addr;
    logic [DW-1:0] lb_rdata;
    logic [DW-1:0] lb_wdata;
    logic          lb_we;

    logic [DW-1:0] relu;
    logic [DW-1:0] hmax;
    logic [DW-1:0] pool;
    logic          row_ok;
    logic          last_win;

    // ReLU and the two unsigned max compares on the datapath
    always_comb begin
        relu     = bus.in_data[DW-1] ? '0 : bus.in_data;
        lb_addr  = col_q[AW:1];
        lb_rdata = line_mem[lb_addr];
        hmax     = (pair_vld_q && (pair_q > relu)) ? pair_q : relu;
        pool     = (lb_rdata > hmax) ? lb_rdata : hmax;
        // An odd column always lies inside a full window; only a trailing
        // odd row (odd IMG_H) can fall outside the pooled grid.
        row_ok   = (row_q >> 1) < PH_C;
        last_win = ((row_q >> 1) == PROW_END) && ((col_q >> 1) == PCOL_END);
    end

    // Next-state: counters, pair register, line-buffer write and output register
    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        pair_d       = pair_q;
        pair_vld_d   = pair_vld_q;
        out_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        out_data_d   = out_data_q;
        out_col_d    = out_col_q;
        out_row_d    = out_row_q;
        lb_we        = 1'b0;
        lb_wdata     = hmax;
        if (bus.clr) begin
            col_d       = '0;
            row_d       = '0;
            pair_d      = '0;
            pair_vld_d  = 1'b0;
            out_data_d  = '0;
            out_col_d   = '0;
            out_row_d   = '0;
        end else if (bus.in_valid) begin
            if (!col_q[0]) begin
                pair_d     = relu;
                pair_vld_d = 1'b1;
            end else begin
                pair_vld_d = 1'b0;
                if (row_ok) begin
                    if (!row_q[0]) begin
                        lb_we = 1'b1;
                    end else begin
                        out_valid_d  = 1'b1;
                        out_data_d   = pool;
                        out_col_d    = col_q >> 1;
                        out_row_d    = row_q >> 1;
                        frame_done_d = last_win;
                    end
                end
            end
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_q        <= '0;
            row_q        <= '0;
            pair_q       <= '0;
            pair_vld_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_col_q    <= '0;
            out_row_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            pair_q       <= pair_d;
            pair_vld_q   <= pair_vld_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_col_q    <= out_col_d;
            out_row_q    <= out_row_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Line-buffer write port; contents are never reset
    always_ff @(posedge clk) begin
        if (lb_we) begin
            line_mem[lb_addr] <= lb_wdata;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_col    = out_col_q;
    assign bus.out_row    = out_row_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_relu_maxpool2x2.sv
// tb/tb_relu_maxpool2x2.sv - randomized bench for relu_maxpool2x2 against a frame-array model
module tb_relu_maxpool2x2;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    relu_maxpool2x2_if #(.DW(9), .CW(5)) if4 ();
    relu_maxpool2x2_if #(.DW(9), .CW(5)) if26 ();
    relu_maxpool2x2_if #(.DW(9), .CW(5)) if5 ();

    relu_maxpool2x2 #(.DW(9), .IMG_W(4),  .IMG_H(4),  .CW(5)) u4  (.clk(clk), .rst_n(rst_n), .bus(if4));
    relu_maxpool2x2 #(.DW(9), .IMG_W(26), .IMG_H(26), .CW(5)) u26 (.clk(clk), .rst_n(rst_n), .bus(if26));
    relu_maxpool2x2 #(.DW(9), .IMG_W(5),  .IMG_H(5),  .CW(5)) u5  (.clk(clk), .rst_n(rst_n), .bus(if5));

    typedef struct {
        int d;
        int c;
        int r;
        int fd;
        int cyc;
    } ev_t;

    ev_t eq0[$];
    ev_t eq1[$];
    ev_t eq2[$];

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int mw[3] = '{4, 26, 5};
    int mh[3] = '{4, 26, 5};
    int mrow[3];
    int mcol[3];
    int img[3][26][26];
    int cnt[3];
    int fdcnt[3];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    endtask

    function automatic int qsize(input int k);
        case (k)
            0: return eq0.size();
            1: return eq1.size();
            default: return eq2.size();
        endcase
    endfunction

    function automatic ev_t qfront(input int k);
        case (k)
            0: return eq0[0];
            1: return eq1[0];
            default: return eq2[0];
        endcase
    endfunction

    task automatic qpop(input int k);
        case (k)
            0: void'(eq0.pop_front());
            1: void'(eq1.pop_front());
            default: void'(eq2.pop_front());
        endcase
    endtask

    task automatic qpush(input int k, input ev_t e);
        case (k)
            0: eq0.push_back(e);
            1: eq1.push_back(e);
            default: eq2.push_back(e);
        endcase
    endtask

    task automatic model_reset(input int k);
        mrow[k] = 0;
        mcol[k] = 0;
    endtask

    // Store the rectified pixel in a frame array; a pixel that closes a
    // full 2x2 window yields the max of those four stored values.
    task automatic model_pix(input int k, input logic [8:0] d);
        int r, c, m;
        ev_t e;
        r = mrow[k];
        c = mcol[k];
        img[k][r][c] = d[8] ? 0 : int'(d);
        if ((r % 2 == 1) && (c % 2 == 1) && (r / 2 < mh[k] / 2) && (c / 2 < mw[k] / 2)) begin
            m = img[k][r-1][c-1];
            if (img[k][r-1][c] > m) m = img[k][r-1][c];
            if (img[k][r][c-1] > m) m = img[k][r][c-1];
            if (img[k][r][c] > m) m = img[k][r][c];
            e.d = m;
            e.c = c / 2;
            e.r = r / 2;
            e.fd = ((r / 2 == mh[k] / 2 - 1) && (c / 2 == mw[k] / 2 - 1)) ? 1 : 0;
            e.cyc = cyc;
            qpush(k, e);
        end
        mcol[k]++;
        if (mcol[k] == mw[k]) begin
            mcol[k] = 0;
            mrow[k]++;
            if (mrow[k] == mh[k]) mrow[k] = 0;
        end
    endtask

    // One clock: drive DUT k (others idle), then advance the model
    task automatic step(input int k, input bit v, input logic [8:0] d, input bit c);
        if4.in_valid = 1'b0;  if4.clr = 1'b0;  if4.in_data = '0;
        if26.in_valid = 1'b0; if26.clr = 1'b0; if26.in_data = '0;
        if5.in_valid = 1'b0;  if5.clr = 1'b0;  if5.in_data = '0;
        case (k)
            0: begin if4.in_valid = v;  if4.in_data = d;  if4.clr = c;  end
            1: begin if26.in_valid = v; if26.in_data = d; if26.clr = c; end
            2: begin if5.in_valid = v;  if5.in_data = d;  if5.clr = c;  end
            default: ;
        endcase
        @(posedge clk);
        cyc++;
        for (int kk = 0; kk < 3; kk++) begin
            if (!rst_n || (kk == k && c)) model_reset(kk);
            else if (kk == k && v) model_pix(kk, d);
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(-1, 1'b0, '0, 1'b0);
    endtask

    task automatic mon(input int k, input logic ov, input logic [8:0] od,
                       input logic [4:0] oc, input logic [4:0] orow, input logic fd);
        ev_t e;
        if (ov === 1'b1) begin
            cnt[k]++;
            if (fd === 1'b1) fdcnt[k]++;
            if (qsize(k) == 0) begin
                check($sformatf("spurious_out%0d", k), 1, 0);
            end else begin
                e = qfront(k);
                qpop(k);
                check($sformatf("latency%0d", k), cyc, e.cyc);
                check($sformatf("data%0d", k), od, e.d);
                check($sformatf("col%0d", k), oc, e.c);
                check($sformatf("row%0d", k), orow, e.r);
                check($sformatf("frame_done%0d", k), fd, e.fd);
            end
        end else begin
            if (fd === 1'b1) check($sformatf("fd_without_valid%0d", k), 1, 0);
            if (qsize(k) != 0) begin
                e = qfront(k);
                if (e.cyc <= cyc) begin
                    check($sformatf("missing_out%0d", k), 0, 1);
                    qpop(k);
                end
            end
        end
    endtask

    always @(negedge clk) mon(0, if4.out_valid, if4.out_data, if4.out_col, if4.out_row, if4.frame_done);
    always @(negedge clk) mon(1, if26.out_valid, if26.out_data, if26.out_col, if26.out_row, if26.frame_done);
    always @(negedge clk) mon(2, if5.out_valid, if5.out_data, if5.out_col, if5.out_row, if5.frame_done);

    task automatic chk_zero(input string tag, input logic ov, input logic [8:0] od,
                            input logic [4:0] oc, input logic [4:0] orow, input logic fd);
        check({tag, "_valid"}, ov, 0);
        check({tag, "_data"}, od, 0);
        check({tag, "_col"}, oc, 0);
        check({tag, "_row"}, orow, 0);
        check({tag, "_fd"}, fd, 0);
    endtask

    task automatic clr_counts();
        for (int k = 0; k < 3; k++) begin
            cnt[k] = 0;
            fdcnt[k] = 0;
        end
    endtask

    task automatic rand_frame(input int k, input int npix, input int stall_pct);
        int sent;
        sent = 0;
        while (sent < npix) begin
            if ($urandom_range(0, 99) < stall_pct) begin
                step(k, 1'b0, 9'($urandom_range(0, 511)), 1'b0);
            end else begin
                step(k, 1'b1, 9'($urandom_range(0, 511)), 1'b0);
                sent++;
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) model_reset(k);
        clr_counts();

        // Reset held with valid random input
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(i, 1'b1, 9'($urandom_range(0, 511)), 1'b0);
            chk_zero("rst4", if4.out_valid, if4.out_data, if4.out_col, if4.out_row, if4.frame_done);
            chk_zero("rst26", if26.out_valid, if26.out_data, if26.out_col, if26.out_row, if26.frame_done);
            chk_zero("rst5", if5.out_valid, if5.out_data, if5.out_col, if5.out_row, if5.frame_done);
        end
        rst_n = 1'b1;
        clr_counts();

        // 4x4 ramp: expect 5,7,13,15
        for (int i = 0; i < 16; i++) step(0, 1'b1, 9'(i), 1'b0);
        idle(2);
        check("ramp_count", cnt[0], 4);
        check("ramp_fd_count", fdcnt[0], 1);

        // ReLU: all negative, then one positive pixel in pooled window (1,1)
        clr_counts();
        for (int i = 0; i < 16; i++) step(0, 1'b1, (i == 5) ? 9'h100 : 9'h1FF, 1'b0);
        for (int i = 0; i < 16; i++) step(0, 1'b1, (i == 11) ? 9'd255 : 9'h1FF, 1'b0);
        idle(2);
        check("relu_count", cnt[0], 8);

        // 26x26 with ~40% stalls
        clr_counts();
        rand_frame(1, 676, 40);
        idle(2);
        check("stall_count", cnt[1], 169);
        check("stall_fd_count", fdcnt[1], 1);

        // Two back-to-back frames
        clr_counts();
        rand_frame(1, 1352, 0);
        idle(2);
        check("wrap_count", cnt[1], 338);
        check("wrap_fd_count", fdcnt[1], 2);

        // clr after pixel 100, then a fresh frame
        rand_frame(1, 101, 20);
        step(1, 1'b1, 9'($urandom_range(0, 511)), 1'b1);
        clr_counts();
        rand_frame(1, 676, 30);
        idle(2);
        check("clr_count", cnt[1], 169);
        check("clr_fd_count", fdcnt[1], 1);

        // Odd 5x5 geometry: 6,8,16,18 then a second frame wraps cleanly
        clr_counts();
        for (int i = 0; i < 25; i++) step(2, 1'b1, 9'(i), 1'b0);
        idle(1);
        check("odd_count", cnt[2], 4);
        check("odd_fd_count", fdcnt[2], 1);
        for (int i = 0; i < 25; i++) step(2, 1'b1, 9'($urandom_range(0, 511)), $urandom_range(0, 0) != 0);
        idle(2);
        check("odd_wrap_count", cnt[2], 8);

        check("leftover4", eq0.size(), 0);
        check("leftover26", eq1.size(), 0);
        check("leftover5", eq2.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
